// File: rtl/svreal_delay_line.sv
// Fixed-point transport delay: converts each sample between binary-point formats with
// saturation, then shifts it through DEPTH stages; a runtime tap picks the observed stage.
module svreal_delay_line #(
  parameter int  WIDTH_IN  = 16,
  parameter int  EXP_IN    = -8,
  parameter int  WIDTH_OUT = 17,
  parameter int  EXP_OUT   = -9,
  parameter int  DEPTH     = 4,
  parameter real INIT      = 0.0,
  parameter int  TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        cke_i,
  input  logic                        flush_i,
  input  logic signed [WIDTH_IN-1:0]  d_i,
  input  logic                        vld_i,
  input  logic        [TAP_W-1:0]     tap_i,
  output logic signed [WIDTH_OUT-1:0] q_o,
  output logic                        vld_o,
  output logic                        sat_o
);

  localparam int S      = EXP_IN - EXP_OUT;
  localparam int SH_L   = (S > 0) ? S : 0;
  localparam int SH_R   = (S < 0) ? -S : 0;
  // One guard bit above the wider of the shifted input and the output keeps the clip compare exact.
  localparam int FULL_W = ((WIDTH_IN + SH_L > WIDTH_OUT) ? WIDTH_IN + SH_L : WIDTH_OUT) + 1;

  localparam logic signed [FULL_W-1:0] SAT_HI =
    {{(FULL_W - WIDTH_OUT + 1){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_LO =
    {{(FULL_W - WIDTH_OUT + 1){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

  function automatic logic signed [WIDTH_OUT-1:0] init_raw_f();
    real x;
    real lim_hi;
    real lim_lo;
    integer r;
    x = INIT;
    for (int i = 0; i < -EXP_OUT; i++) x = x * 2.0;
    for (int i = 0; i < EXP_OUT; i++) x = x / 2.0;
    lim_hi = 1.0;
    for (int i = 0; i < WIDTH_OUT - 1; i++) lim_hi = lim_hi * 2.0;
    lim_lo = -lim_hi;
    lim_hi = lim_hi - 1.0;
    if (x > lim_hi) x = lim_hi;
    if (x < lim_lo) x = lim_lo;
    r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return WIDTH_OUT'(r);
  endfunction

  localparam logic signed [WIDTH_OUT-1:0] INIT_RAW = init_raw_f();

  function automatic logic signed [FULL_W-1:0] align_f(input logic signed [WIDTH_IN-1:0] x);
    logic signed [FULL_W-1:0] ext;
    ext = {{(FULL_W - WIDTH_IN){x[WIDTH_IN-1]}}, x};
    return (ext <<< SH_L) >>> SH_R;
  endfunction

  // Returns {ovf, clipped value}.
  function automatic logic [WIDTH_OUT:0] sat_f(input logic signed [FULL_W-1:0] v);
    if (v > SAT_HI)      return {1'b1, SAT_HI[WIDTH_OUT-1:0]};
    else if (v < SAT_LO) return {1'b1, SAT_LO[WIDTH_OUT-1:0]};
    else                 return {1'b0, v[WIDTH_OUT-1:0]};
  endfunction

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);

  logic [WIDTH_OUT:0]          conv_res;
  logic signed [WIDTH_OUT-1:0] stage_p [DEPTH];
  logic                        vld_p   [DEPTH];
  logic                        sat_q;
  logic [TAP_W-1:0]            tap_sel;

  assign conv_res = sat_f(align_f(d_i));

  // Stage 0 captures the converted sample; stages 1..DEPTH-1 shift on enabled edges.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_p[k] <= INIT_RAW;
        vld_p[k]   <= 1'b0;
      end
      sat_q <= 1'b0;
    end else if (cke_i) begin
      stage_p[0] <= conv_res[WIDTH_OUT-1:0];
      vld_p[0]   <= vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_p[k] <= stage_p[k-1];
        vld_p[k]   <= vld_p[k-1];
      end
      sat_q <= sat_q | (vld_i & conv_res[WIDTH_OUT]);
    end
  end

  // Combinational tap mux, out-of-range taps clamp to the last stage.
  assign tap_sel = (tap_i > LAST_TAP) ? LAST_TAP : tap_i;

  always_comb begin
    q_o   = stage_p[0];
    vld_o = vld_p[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (tap_sel == TAP_W'(k)) begin
        q_o   = stage_p[k];
        vld_o = vld_p[k];
      end
    end
  end

  assign sat_o = sat_q;

endmodule

// File: tb/tb_svreal_delay_line.sv
// Scoreboard bench for svreal_delay_line: two differently parameterised instances share stimulus.
module tb_svreal_delay_line;

  localparam int EIN = -8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, cke, flush, vld;
  logic signed [15:0] d;
  logic [1:0]         tap;
  logic signed [11:0] q_a;
  logic               vld_a, sat_a;
  logic signed [16:0] q_b;
  logic               vld_b, sat_b;

  // A: saturating left shift, INIT 0.5, DEPTH 3. B: rounding right shift, DEPTH 4.
  svreal_delay_line #(.WIDTH_IN(16), .EXP_IN(-8), .WIDTH_OUT(12), .EXP_OUT(-9),
                      .DEPTH(3), .INIT(0.5), .TAP_W(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .flush_i(flush), .d_i(d), .vld_i(vld),
    .tap_i(tap), .q_o(q_a), .vld_o(vld_a), .sat_o(sat_a));

  svreal_delay_line #(.WIDTH_IN(16), .EXP_IN(-8), .WIDTH_OUT(17), .EXP_OUT(-6),
                      .DEPTH(4), .INIT(0.0), .TAP_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .flush_i(flush), .d_i(d), .vld_i(vld),
    .tap_i(tap), .q_o(q_b), .vld_o(vld_b), .sat_o(sat_b));

  int n_cmp = 0;
  int n_err = 0;
  int exp_a[$];
  int exp_b[$];
  bit exp_sat_a = 1'b0;
  bit exp_sat_b = 1'b0;
  bit last_en   = 1'b0;
  bit mon_en    = 1'b0;

  // value * 2**(EIN-exp_out), floor rounding, clipped to w_out bits.
  function automatic int ref_conv(input int x, input int exp_out, input int w_out, output bit ovf);
    int s;
    longint v, hi, lo, dv;
    s = EIN - exp_out;
    if (s >= 0) begin
      v = longint'(x) * (longint'(1) << s);
    end else begin
      dv = longint'(1) << (-s);
      v  = (x >= 0) ? longint'(x) / dv : -((-longint'(x) + dv - 1) / dv);
    end
    hi  = (longint'(1) << (w_out - 1)) - 1;
    lo  = -(longint'(1) << (w_out - 1));
    ovf = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit ce, input bit fl, input bit v, input int x);
    bit oa, ob;
    int ea, eb;
    rst_n = rn; cke = ce; flush = fl; vld = v; d = 16'(x);
    @(posedge clk);
    if (!rn || fl) begin
      exp_a.delete();
      exp_b.delete();
      exp_sat_a = 1'b0;
      exp_sat_b = 1'b0;
    end else if (ce && v) begin
      ea = ref_conv(x, -9, 12, oa);
      eb = ref_conv(x, -6, 17, ob);
      exp_a.push_back(ea);
      exp_b.push_back(eb);
      exp_sat_a = exp_sat_a | oa;
      exp_sat_b = exp_sat_b | ob;
    end
    last_en = rn && !fl && ce;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_out(input string nm, input int qa, input int va, input int qb, input int vb);
    chk({nm, "_q_a"}, int'(q_a), qa);
    chk({nm, "_vld_a"}, int'(vld_a), va);
    chk({nm, "_q_b"}, int'(q_b), qb);
    chk({nm, "_vld_b"}, int'(vld_b), vb);
  endtask

  // Monitor: each sample that newly reaches the observed stage after an enabled edge is popped.
  always @(negedge clk) begin
    if (mon_en) begin
      if (last_en && vld_a) begin
        if (exp_a.size() == 0) chk("sb_a_spurious", 1, 0);
        else chk("sb_a", int'(q_a), exp_a.pop_front());
      end
      if (last_en && vld_b) begin
        if (exp_b.size() == 0) chk("sb_b_spurious", 1, 0);
        else chk("sb_b", int'(q_b), exp_b.pop_front());
      end
      chk("sat_a", int'(sat_a), int'(exp_sat_a));
      chk("sat_b", int'(sat_b), int'(exp_sat_b));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tap = 2'd0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 123);
    mon_en = 1'b1;

    // Reset state on every tap.
    for (int t = 0; t < 4; t++) begin
      tap = 2'(t);
      #1;
      chk_out("reset", 256, 0, 0, 0);
      chk("reset_sat_a", int'(sat_a), 0);
    end

    // Format and latency.
    tap = 2'd2;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 384);
    chk("lat_e1", int'(vld_a), 0);
    idle(1);
    chk("lat_e2", int'(vld_a), 0);
    idle(1);
    chk_out("lat_e3", 768, 1, 96, 1);
    idle(1);
    chk("lat_e4", int'(vld_a), 0);

    // Clock-enable gating, including a valid sample offered while held.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 384);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, (i == 2), 1000);
      chk_out("hold", 256, 0, 0, 0);
    end
    idle(1);
    chk_out("after_hold", 768, 1, 96, 1);

    // Saturation and sticky flag.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    tap = 2'd0;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 25600);
    chk_out("sat_pos", 2047, 1, 6400, 1);
    chk("sat_pos_flag", int'(sat_a), 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, -25600);
    chk_out("sat_neg", -2048, 1, -6400, 1);
    idle(2);
    chk("sat_sticky", int'(sat_a), 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("sat_flushed", int'(sat_a), 0);

    // Right shift rounds toward -inf.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 7);
    chk_out("rsh_pos", 14, 1, 1, 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, -7);
    chk_out("rsh_neg", -14, 1, -2, 1);

    // Tap clamp, then flush colliding with a valid sample.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    tap = 2'd3;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, i);
    chk_out("clamp", 4, 1, 0, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 9);
    for (int t = 0; t < 4; t++) begin
      tap = 2'(t);
      #1;
      chk_out("flush", 256, 0, 0, 0);
    end
    idle(4);
    chk_out("flush_drop", 0, 0, 0, 0);

    // Randomised traffic with occasional flush/reset.
    for (int blk = 0; blk < 4; blk++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
      tap = 2'($urandom_range(0, 3));
      for (int i = 0; i < 150; i++) begin
        cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6),
              int'($urandom_range(0, 65535)) - 32768);
      end
      idle(4);
      chk("drain_a", exp_a.size(), 0);
      chk("drain_b", exp_b.size(), 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
